// File: rtl/flu_pfifo_drop_pkg.sv
// Shared types for the FLU packet FIFO with drop: write FSM encoding and pointer sizing.
package flu_pfifo_drop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DROP
  } wr_state_e;

  // Pointers carry one wrap bit above the address so full and empty can be told apart.
  function automatic int ptr_width(input int items);
    return $clog2(items) + 1;
  endfunction

endpackage

// File: rtl/flu_pfifo_drop_if.sv
// FrameLink Unaligned stream bundle; discard is only meaningful on the receive side.
interface flu_pfifo_drop_if #(
  parameter int DATA_WIDTH    = 512,
  parameter int SOP_POS_WIDTH = 3,
  parameter int EOP_POS_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]    data;
  logic [SOP_POS_WIDTH-1:0] sop_pos;
  logic [EOP_POS_WIDTH-1:0] eop_pos;
  logic                     sop;
  logic                     eop;
  logic                     src_rdy;
  logic                     dst_rdy;
  logic                     discard;

  modport master (output data, sop_pos, eop_pos, sop, eop, src_rdy, discard, input dst_rdy);
  modport slave  (input data, sop_pos, eop_pos, sop, eop, src_rdy, discard, output dst_rdy);
endinterface

// File: rtl/flu_pfifo_drop_mem.sv
// Simple dual-port RAM, one write port and one registered read port on a single clock.
module flu_pfifo_drop_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/flu_pfifo_drop.sv
// Store-and-forward FLU packet FIFO: packets become readable only after a clean EOP.
// Write FSM: IDLE waits for SOP | WRITE stores words | DROP swallows words until EOP.
module flu_pfifo_drop
  import flu_pfifo_drop_pkg::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int SOP_POS_WIDTH = 3,
  parameter int ITEMS         = 512,
  parameter int STATUS_WIDTH  = 4,
  parameter bit DISCARD_EN    = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  flu_pfifo_drop_if.slave         rx,
  flu_pfifo_drop_if.master        tx,
  output logic [STATUS_WIDTH-1:0] status_o,
  output logic                    drop_ovf_o,
  output logic                    drop_disc_o
);
  localparam int EOP_POS_WIDTH = $clog2(DATA_WIDTH / 8);
  localparam int AW    = $clog2(ITEMS);
  localparam int PW    = ptr_width(ITEMS);
  localparam int MEM_W = DATA_WIDTH + SOP_POS_WIDTH + EOP_POS_WIDTH + 1;
  localparam logic [PW-1:0] ITEMS_P = PW'(ITEMS);
  localparam logic [PW-1:0] MAX_LEN = PW'(ITEMS - 1);
  localparam logic [PW-1:0] ST_MAX  = PW'((1 << STATUS_WIDTH) - 1);

  wr_state_e state_q, state_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, commit_q, commit_d, start_q, start_d;
  logic [PW-1:0] start_addr, roll_addr, used, used_sh;
  logic [AW-1:0] waddr;
  logic [EOP_POS_WIDTH-1:0] sop_byte;
  logic [STATUS_WIDTH-1:0]  status_q, status_d;
  logic [MEM_W-1:0]         rdata;
  logic start_sh_q, start_sh_d;
  logic fire, single, shared, disc, full, too_long, can_wr, rollback, do_start;
  logic we, w_eop, sop_clr, ovf_d, disc_d, drop_ovf_q, drop_disc_q;
  logic rd_en, tx_valid_q, tx_sop_q;
  logic sop_flags_q [ITEMS];

  assign rx.dst_rdy = ~reset_i;
  assign fire       = rx.src_rdy & rx.dst_rdy;
  assign sop_byte   = EOP_POS_WIDTH'(rx.sop_pos) << (EOP_POS_WIDTH - SOP_POS_WIDTH);
  assign single     = rx.sop & rx.eop & (sop_byte <= rx.eop_pos);
  assign shared     = rx.sop & rx.eop & (sop_byte > rx.eop_pos);
  assign disc       = DISCARD_EN & rx.discard;
  assign used       = wr_q - rd_q;
  assign full       = (used == ITEMS_P);
  assign too_long   = ((wr_q - start_q) >= MAX_LEN);
  assign roll_addr  = start_q + {{(PW-1){1'b0}}, start_sh_q};

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    commit_d   = commit_q;
    start_d    = start_q;
    start_sh_d = start_sh_q;
    we         = 1'b0;
    waddr      = wr_q[AW-1:0];
    w_eop      = rx.eop;
    sop_clr    = 1'b0;
    ovf_d      = 1'b0;
    disc_d     = 1'b0;
    rollback   = 1'b0;
    do_start   = 1'b0;
    start_addr = wr_q;
    can_wr     = 1'b0;
    if (fire) begin
      case (state_q)
        ST_IDLE: do_start = rx.sop;
        ST_WRITE: begin
          if (rx.eop && (full || too_long || disc)) begin
            rollback = 1'b1;
            ovf_d    = full | too_long;
            disc_d   = ~(full | too_long);
          end else if (rx.eop) begin
            we   = 1'b1;
            wr_d = wr_q + 1'b1;
            // A shared last word stays uncommitted until the packet it opens resolves.
            if (shared) begin
              commit_d   = wr_q;
              start_d    = wr_q;
              start_sh_d = 1'b1;
            end else begin
              commit_d = wr_q + 1'b1;
              state_d  = ST_IDLE;
            end
          end else if (full || too_long) begin
            state_d = ST_DROP;
          end else begin
            we   = 1'b1;
            wr_d = wr_q + 1'b1;
          end
        end
        ST_DROP: begin
          rollback = rx.eop;
          ovf_d    = rx.eop;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (rollback) begin
      wr_d    = roll_addr;
      state_d = ST_IDLE;
      if (start_sh_q) begin
        sop_clr  = 1'b1;
        commit_d = roll_addr;
      end
      if (shared) begin
        do_start   = 1'b1;
        start_addr = roll_addr;
      end
    end
    if (do_start) begin
      can_wr     = ((start_addr - rd_q) != ITEMS_P);
      waddr      = start_addr[AW-1:0];
      start_d    = start_addr;
      start_sh_d = 1'b0;
      if (single) begin
        state_d = ST_IDLE;
        if (!can_wr) ovf_d = 1'b1;
        else if (disc) disc_d = 1'b1;
        else begin
          we       = 1'b1;
          wr_d     = start_addr + 1'b1;
          commit_d = start_addr + 1'b1;
        end
      end else begin
        w_eop = 1'b0;
        if (can_wr) begin
          we      = 1'b1;
          wr_d    = start_addr + 1'b1;
          state_d = ST_WRITE;
        end else begin
          wr_d    = start_addr;
          state_d = ST_DROP;
        end
      end
    end
  end

  assign used_sh  = used >> (AW - STATUS_WIDTH);
  assign status_d = (used_sh > ST_MAX) ? '1 : used_sh[STATUS_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      wr_q        <= '0;
      commit_q    <= '0;
      start_q     <= '0;
      start_sh_q  <= 1'b0;
      status_q    <= '0;
      drop_ovf_q  <= 1'b0;
      drop_disc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      commit_q    <= commit_d;
      start_q     <= start_d;
      start_sh_q  <= start_sh_d;
      status_q    <= status_d;
      drop_ovf_q  <= ovf_d;
      drop_disc_q <= disc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) sop_flags_q[waddr] <= rx.sop;
    if (sop_clr) sop_flags_q[start_q[AW-1:0]] <= 1'b0;
  end

  // The RAM read register doubles as the TX output register.
  assign rd_en = (rd_q != commit_q) && (!tx_valid_q || tx.dst_rdy);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q       <= '0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
    end else if (rd_en) begin
      rd_q       <= rd_q + 1'b1;
      tx_valid_q <= 1'b1;
      tx_sop_q   <= sop_flags_q[rd_q[AW-1:0]];
    end else if (tx.dst_rdy) begin
      tx_valid_q <= 1'b0;
    end
  end

  flu_pfifo_drop_mem #(.WIDTH(MEM_W), .DEPTH(ITEMS)) u_mem (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i ({rx.data, rx.sop_pos, rx.eop_pos, w_eop}),
    .re_i    (rd_en),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (rdata)
  );

  assign tx.data    = rdata[MEM_W-1 -: DATA_WIDTH];
  assign tx.sop_pos = rdata[EOP_POS_WIDTH+1 +: SOP_POS_WIDTH];
  assign tx.eop_pos = rdata[1 +: EOP_POS_WIDTH];
  assign tx.eop     = rdata[0];
  assign tx.sop     = tx_sop_q;
  assign tx.src_rdy = tx_valid_q;
  assign tx.discard = 1'b0;

  assign status_o    = status_q;
  assign drop_ovf_o  = drop_ovf_q;
  assign drop_disc_o = drop_disc_q;
endmodule

// File: tb/tb_flu_pfifo_drop.sv
// Scoreboard bench for flu_pfifo_drop: stimulus pushes expected TX words, a monitor pops and compares.
module tb_flu_pfifo_drop;
  localparam int DW = 64, SPW = 3, EPW = 3, ITEMS = 16, SW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [SW-1:0] status;
  logic drop_ovf, drop_disc;
  int vectors = 0, fails = 0, ovf_cnt = 0, disc_cnt = 0;
  logic [71:0] exp_q[$];

  flu_pfifo_drop_if #(.DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW), .EOP_POS_WIDTH(EPW)) rx ();
  flu_pfifo_drop_if #(.DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW), .EOP_POS_WIDTH(EPW)) tx ();

  flu_pfifo_drop #(
    .DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW), .ITEMS(ITEMS), .STATUS_WIDTH(SW), .DISCARD_EN(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .rx(rx), .tx(tx),
    .status_o(status), .drop_ovf_o(drop_ovf), .drop_disc_o(drop_disc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (drop_ovf === 1'b1) ovf_cnt++;
    if (drop_disc === 1'b1) disc_cnt++;
    if (!reset && tx.src_rdy && tx.dst_rdy) begin
      if (exp_q.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL tx_unexpected: got word %h, expected none", tx.data);
      end else begin
        check("tx_word", {tx.data, tx.sop_pos, tx.eop_pos, tx.sop, tx.eop}, exp_q.pop_front());
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic sop, input logic [2:0] sp,
                           input logic eop, input logic [2:0] ep, input logic disc);
    rx.data = d; rx.sop = sop; rx.sop_pos = sp; rx.eop = eop; rx.eop_pos = ep;
    rx.discard = disc; rx.src_rdy = 1'b1;
    @(posedge clk); #1;
    rx.src_rdy = 1'b0; rx.sop = 1'b0; rx.eop = 1'b0; rx.discard = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [2:0] ep, input bit disc, input bit keep);
    logic [63:0] d;
    logic s, e;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      s = (i == 0);
      e = (i == n - 1);
      if (keep) exp_q.push_back({d, 3'd0, ep, s, e});
      send_word(d, s, 3'd0, e, ep, disc && e);
    end
  endtask

  task automatic drain(input string name);
    tx.dst_rdy = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, 72'(exp_q.size()), 72'd0);
    check({name, "_idle"}, 72'(tx.src_rdy), 72'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d0, d1, d2;
    logic [2:0] ep;
    bit rdy_low, tx_busy;
    int sent, guard;

    reset = 1'b1;
    rx.data = '0; rx.sop_pos = '0; rx.eop_pos = '0; rx.sop = 1'b0; rx.eop = 1'b0;
    rx.src_rdy = 1'b0; rx.discard = 1'b0; tx.dst_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_src_rdy", 72'(tx.src_rdy), 72'd0);
    check("rst_rx_dst_rdy", 72'(rx.dst_rdy), 72'd0);
    check("rst_status", 72'(status), 72'd0);
    check("rst_drop_ovf", 72'(drop_ovf), 72'd0);
    check("rst_drop_disc", 72'(drop_disc), 72'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rx_dst_rdy_run", 72'(rx.dst_rdy), 72'd1);

    // 64 B packet: TX valid appears two cycles after the EOP handshake
    tx.dst_rdy = 1'b1;
    send_pkt(8, 3'd7, 1'b0, 1'b1);
    check("lat_eop_plus1", 72'(tx.src_rdy), 72'd0);
    @(posedge clk); #1;
    check("lat_eop_plus2", 72'(tx.src_rdy), 72'd1);
    drain("t1_drain");

    // discarded 3-word packet followed by good 2-word packet
    send_pkt(3, 3'd5, 1'b1, 1'b0);
    send_pkt(2, 3'd2, 1'b0, 1'b1);
    drain("t2_drain");
    check("t2_disc_cnt", 72'(disc_cnt), 72'd1);
    check("t2_ovf_cnt", 72'(ovf_cnt), 72'd0);

    // shared word: A ends where B starts, B is discarded so A's last word loses its SOP
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    exp_q.push_back({d0, 3'd0, 3'd0, 1'b1, 1'b0});
    exp_q.push_back({d1, 3'd5, 3'd3, 1'b0, 1'b1});
    send_word(d0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    send_word(d1, 1'b1, 3'd5, 1'b1, 3'd3, 1'b0);
    send_word(d2, 1'b0, 3'd0, 1'b1, 3'd4, 1'b1);
    drain("t4_drain");
    check("t4_disc_cnt", 72'(disc_cnt), 72'd2);

    // 20-word packet into a 16-deep FIFO with TX stalled
    tx.dst_rdy = 1'b0;
    rdy_low = 1'b0; tx_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_word({$urandom, $urandom}, i == 0, 3'd0, i == 19, 3'd7, 1'b0);
      if (!rx.dst_rdy) rdy_low = 1'b1;
      if (tx.src_rdy) tx_busy = 1'b1;
      if (i == 18) check("t3_status_peak", 72'(status), 72'd15);
    end
    repeat (2) @(posedge clk);
    #1;
    check("t3_status_empty", 72'(status), 72'd0);
    check("t3_ovf_cnt", 72'(ovf_cnt), 72'd1);
    check("t3_rx_rdy_low", 72'(rdy_low), 72'd0);
    check("t3_tx_busy", 72'(tx_busy), 72'd0);

    // longest packet that still fits: ITEMS-1 words
    send_pkt(ITEMS - 1, 3'd1, 1'b0, 1'b1);
    drain("t3b_drain");
    check("t3b_ovf_cnt", 72'(ovf_cnt), 72'd1);

    // back-to-back single-word packets with random TX readiness
    sent = 0; guard = 0;
    while (sent < 1000 && guard < 20000) begin
      guard++;
      tx.dst_rdy = 1'($urandom_range(0, 1));
      if (exp_q.size() < ITEMS - 4) begin
        d0 = {$urandom, $urandom};
        ep = 3'($urandom_range(0, 7));
        exp_q.push_back({d0, 3'd0, ep, 1'b1, 1'b1});
        send_word(d0, 1'b1, 3'd0, 1'b1, ep, 1'b0);
        sent++;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("t5_sent", 72'(sent), 72'd1000);
    drain("t5_drain");
    check("t5_ovf_cnt", 72'(ovf_cnt), 72'd1);

    // reset in the middle of a packet, then an orphan word, then a good packet
    send_word({$urandom, $urandom}, 1'b1, 3'd0, 1'b0, 3'd7, 1'b0);
    send_word({$urandom, $urandom}, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_tx_src_rdy", 72'(tx.src_rdy), 72'd0);
    check("t6_rst_rx_dst_rdy", 72'(rx.dst_rdy), 72'd0);
    check("t6_rst_status", 72'(status), 72'd0);
    check("t6_rst_drops", 72'({drop_ovf, drop_disc}), 72'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    send_word({$urandom, $urandom}, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0);
    send_pkt(3, 3'd6, 1'b0, 1'b1);
    drain("t6_drain");
    check("t6_drop_cnts", 72'({ovf_cnt[7:0], disc_cnt[7:0]}), 72'h0102);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/flu_pfifo_drop.md
# flu_pfifo_drop

Single-clock FrameLink Unaligned (FLU) packet FIFO with store-and-forward commit and packet drop. It is the successor of the dual-clock FLU packet FIFO: it adds per-packet discard on request, lossless-to-the-sender overflow handling, and drop reporting. It sits between a packet source that must never be back-pressured (MAC/parser) and downstream FLU logic. A packet becomes visible on TX only after its EOP word has been accepted without error.

## Interface
- DATA_WIDTH, 512: FLU data width in bits; multiple of 64.
- SOP_POS_WIDTH, 3: SOP position width (block granularity).
- ITEMS, 512: storage depth in words; power of two, at least 4.
- STATUS_WIDTH, 4: width of the occupancy status output.
- DISCARD_EN, true: when false, RX_DISCARD is ignored.

Ports:
- CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high.
- RX_DATA  in  DATA_WIDTH  FLU data.
- RX_SOP_POS  in  SOP_POS_WIDTH  SOP block index.
- RX_EOP_POS  in  log2(DATA_WIDTH/8)  EOP byte index.
- RX_SOP, RX_EOP, RX_SRC_RDY  in  1  FLU control.
- RX_DST_RDY  out  1  0 during RESET, 1 otherwise (never back-pressures).
- RX_DISCARD  in  1  valid with the EOP word; 1 drops the packet ending in this word.
- TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP, TX_SRC_RDY  out  as RX  FLU output.
- TX_DST_RDY  in  1  downstream ready.
- STATUS  out  STATUS_WIDTH  MSBs of used-word count, saturated at all-ones.
- DROP_OVF  out  1  one-cycle pulse: packet dropped on overflow.
- DROP_DISC  out  1  one-cycle pulse: packet dropped via RX_DISCARD.

## Operation
- Pointers are log2(ITEMS)+1 bits: wr_ptr, rd_ptr, commit_ptr. used = wr_ptr − rd_ptr. Full when used == ITEMS.
- Write FSM:
  - IDLE: a word without SOP is consumed and not written.
  - SOP word goes to WRITE. A single-word packet is one with SOP pos ≤ EOP pos, both flags set.
  - WRITE: each word is written. A word arriving when full goes to DROP.
  - DROP: words are consumed and not written until EOP.
  - At EOP, the FSM goes to IDLE, or to WRITE/DROP if the same word carries the SOP of the next packet (shared word).
- Commit at EOP of a good packet: commit_ptr = address after its EOP word. If that word is shared, commit_ptr = its address instead, so the shared word is held until the next packet resolves.
- Drop, at EOP in DROP state, or RX_DISCARD=1 with DISCARD_EN. Let S be the packet start address and R the rollback address: R = S+1 if the packet started in a shared word, else S.
  - If started shared: clear the stored SOP flag of word S and set commit_ptr = S+1.
  - If the current word also carries a new SOP: write it at R with its EOP flag cleared, set wr_ptr = R+1, and treat the new packet as non-shared.
  - Otherwise wr_ptr = R.
  - Pulse DROP_OVF or DROP_DISC the next cycle. Overflow takes priority if both apply.
- Data/SOP_POS/EOP_POS/EOP are kept in RAM; SOP flags are kept in a register array so they can be cleared.
- Read side: prefetch while rd_ptr != commit_ptr into a one-word output register.
- Packets longer than ITEMS−1 words are always dropped.

## Timing
- Reset values: TX_SRC_RDY 0, RX_DST_RDY 0, STATUS 0, DROP_* 0, all pointers 0, FSM IDLE.
- Reset mid-packet: all content is lost. Words without SOP after reset are discarded.
- Latency: EOP accepted in cycle t → commit at t+1 → TX_SRC_RDY=1 at t+2 when the FIFO is empty.
- TX handshake: a word transfers when TX_SRC_RDY and TX_DST_RDY are both high. TX outputs are stable while TX_DST_RDY=0. Full throughput is one word per cycle.
- A write and a read in the same cycle are allowed. Full is evaluated on pre-write used, including a read in that cycle.
- STATUS is registered and lags used by one cycle.

## Structure
- Shared package flu_pfifo_drop_pkg: FSM enum (IDLE, WRITE, DROP) and the pointer-width constant function.
- One sub-module, flu_pfifo_drop_mem: single-clock simple-dual-port RAM, 1-cycle read, width DATA_WIDTH+SOP_POS_WIDTH+EOP_POS width+1.

## Test plan
- Single 64 B packet into an empty FIFO, TX_DST_RDY=1 → TX_SRC_RDY rises 2 cycles after the EOP handshake; data is identical.
- RX_DISCARD=1 on a 3-word packet, then a good 2-word packet → DROP_DISC pulses once; only the 2-word packet appears on TX.
- ITEMS=16, TX_DST_RDY=0, 20-word packet → DROP_OVF pulses; RX_DST_RDY stays 1; TX stays idle; used returns to 0.
- Shared word (EOP of A + SOP of B), B discarded → A emitted with TX_SOP=0 in its last word; B absent.
- Back-to-back 1-word packets with random TX_DST_RDY (50%) over 1000 packets → order and content preserved, no loss.
- RESET asserted mid-packet → outputs take reset values the next cycle; the next SOP packet passes correctly.
